// File: rtl/booth_pkg.sv
// Shared types for the radix-8 sequential Booth multiplier: FSM states,
// signed Booth digit and the window-to-digit encoder.
package booth_pkg;

  localparam int DIG_BITS = 3;  // multiplier bits retired per iteration

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef logic signed [3:0] digit_t;

  // w = {b[3i+2], b[3i+1], b[3i], b[3i-1]} -> digit in -4..+4
  function automatic digit_t booth_encode(input logic [3:0] w);
    int v;
    v = -4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
    return digit_t'(v);
  endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Request/response bundle of booth_mult_seq; slave side is the multiplier.
interface booth_mult_seq_if #(parameter int WIDTH = 32);
  logic               req_valid;
  logic               req_ready;
  logic               req_signed;
  logic               req_acc;
  logic [WIDTH-1:0]   req_a;
  logic [WIDTH-1:0]   req_b;
  logic [2*WIDTH-1:0] acc_in;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_hi;
  logic [WIDTH-1:0]   rsp_lo;
  logic               busy;

  modport slave (
    input  req_valid, req_signed, req_acc, req_a, req_b, acc_in, rsp_ready,
    output req_ready, rsp_valid, rsp_hi, rsp_lo, busy
  );

  modport master (
    output req_valid, req_signed, req_acc, req_a, req_b, acc_in, rsp_ready,
    input  req_ready, rsp_valid, rsp_hi, rsp_lo, busy
  );
endinterface

// File: rtl/booth_recode8.sv
// Radix-8 Booth recoder: 4-bit multiplier window to one-hot magnitude + sign.
module booth_recode8
  import booth_pkg::*;
(
  input  logic [3:0] win_i,
  output logic [4:0] mag_oh_o,
  output logic       neg_o
);
  digit_t     d;
  logic [2:0] mag;

  always_comb begin
    d        = booth_encode(win_i);
    neg_o    = d[3];
    mag      = neg_o ? 3'(-d) : 3'(d);
    mag_oh_o = 5'b00001 << mag;
  end
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-8 Booth multiply(-accumulate): one digit per cycle,
// result = (acc ? acc_in : 0) + a*b mod 2^(2*WIDTH).
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset_l,
  booth_mult_seq_if.slave bus
);
  localparam int NDIG = (WIDTH + 3) / 3;
  localparam int PW   = 2 * WIDTH;
  localparam int BW   = DIG_BITS * NDIG;
  localparam int CW   = $clog2(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   a_q, a3_q;
  logic [BW:0]     b_q;       // bit 0 is the bit below the current window
  logic            acc_en_q;
  logic            rsp_valid_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [4:0]      mag_oh;
  logic            neg;
  logic [PW-1:0]   sel, addend;
  logic            a_ext, b_ext;

  assign a_ext = bus.req_signed & bus.req_a[WIDTH-1];
  assign b_ext = bus.req_signed & bus.req_b[WIDTH-1];

  booth_recode8 u_rec (
    .win_i   (b_q[3:0]),
    .mag_oh_o(mag_oh),
    .neg_o   (neg)
  );

  // a_q / a3_q are pre-shifted by 3i, so the partial product needs no shifter
  always_comb begin
    sel = '0;
    if (mag_oh[1])      sel = a_q;
    else if (mag_oh[2]) sel = a_q << 1;
    else if (mag_oh[3]) sel = a3_q;
    else if (mag_oh[4]) sel = a_q << 2;
    addend = neg ? (~sel + PW'(1)) : sel;
    acc_d  = acc_q + addend;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      a3_q        <= '0;
      b_q         <= '0;
      acc_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.req_valid) begin
          a_q      <= {{WIDTH{a_ext}}, bus.req_a};
          b_q      <= {{(BW-WIDTH){b_ext}}, bus.req_b, 1'b0};
          a3_q     <= bus.acc_in;  // addend parked here until PRE
          acc_en_q <= bus.req_acc;
          state_q  <= PRE;
        end
        PRE: begin
          acc_q   <= acc_en_q ? a3_q : '0;
          a3_q    <= a_q + (a_q << 1);
          cnt_q   <= '0;
          state_q <= ITER;
        end
        ITER: begin
          acc_q <= acc_d;
          a_q   <= a_q  << DIG_BITS;
          a3_q  <= a3_q << DIG_BITS;
          b_q   <= b_q  >> DIG_BITS;
          if (cnt_q == LAST) state_q <= DONE;
          else               cnt_q   <= cnt_q + CW'(1);
        end
        DONE: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            hi_q        <= acc_q[PW-1:WIDTH];
            lo_q        <= acc_q[WIDTH-1:0];
          end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hi    = hi_q;
  assign bus.rsp_lo    = lo_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at WIDTH=32.
module tb_booth_mult_seq;
  localparam int W   = 32;
  localparam int LAT = 13;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [63:0] sb_q[$];

  booth_mult_seq_if #(.WIDTH(W)) bus();

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset_l(reset_l),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic acc,
                                        input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [63:0] ai);
    logic [63:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return (acc ? ai : 64'd0) + ea * eb;
  endfunction

  // Called at #1 after an edge; returns at #1 after the accepting edge.
  task automatic send(input logic s, input logic acc, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [63:0] ai,
                      input logic [63:0] exp, output int waited);
    waited = 0;
    bus.req_valid  = 1'b1;
    bus.req_signed = s;
    bus.req_acc    = acc;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.acc_in     = ai;
    while (!bus.req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;  // fields must have been captured already
    bus.req_b     = $urandom;
    bus.acc_in    = {$urandom, $urandom};
    sb_q.push_back(exp);
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
  endtask

  task automatic get_rsp(input string tag, input int hold);
    int lat;
    logic [63:0] got;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.rsp_valid) begin
      chk("rsp_timeout", 64'd0, 64'd1);
      void'(sb_q.pop_front());
      return;
    end
    chk("latency", 64'(lat), 64'(LAT));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_data", {bus.rsp_hi, bus.rsp_lo}, sb_q[0]);
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    got = {bus.rsp_hi, bus.rsp_lo};
    chk("hs_req_ready", 64'(bus.req_ready), 64'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk(tag, got, sb_q.pop_front());
    chk("ready_after_hs", 64'(bus.req_ready), 64'd1);
    chk("valid_after_hs", 64'(bus.rsp_valid), 64'd0);
  endtask

  task automatic txn(input string tag, input logic s, input logic acc,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [63:0] ai, input logic [63:0] exp, input int hold);
    int w;
    send(s, acc, a, b, ai, exp, w);
    get_rsp(tag, hold);
  endtask

  initial begin
    int w, nv;
    logic s, acc;
    logic [W-1:0] a, b;
    logic [63:0] ai;

    bus.req_valid = 1'b0; bus.req_signed = 1'b0; bus.req_acc = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.acc_in = '0; bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rsp", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
    reset_l = 1'b1;

    txn("u_3x5", 1'b0, 1'b0, 32'd3, 32'd5, 64'd0, 64'h0000_0000_0000_000F, 0);
    txn("u_max_sq", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 0);
    txn("s_m1_sq", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_0000_0001, 0);
    txn("s_min_sq", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'd0, 64'h4000_0000_0000_0000, 0);
    txn("s_m3x7", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    txn("acc_wrap", 1'b0, 1'b1, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);

    // Stall the response, then a back-to-back request right after handshake
    txn("stall", 1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 64'h0123_4567_89AB_CDEF,
        model(1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 64'h0123_4567_89AB_CDEF), 5);
    send(1'b0, 1'b0, 32'd6, 32'd7, 64'd0, 64'd42, w);
    chk("accept_after_hs", 64'(w), 64'd0);
    get_rsp("b2b_6x7", 0);

    // Reset in ITER digit 4: operation must vanish
    send(1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678, 64'd0, 64'd0, w);
    repeat (5) @(posedge clk);
    #1;
    reset_l = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_rsp", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
    sb_q.delete();
    @(posedge clk); #1;
    reset_l = 1'b1;
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd1);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) nv++;
    end
    chk("no_rsp_after_rst", 64'(nv), 64'd0);
    txn("post_rst_2x2", 1'b0, 1'b0, 32'd2, 32'd2, 64'd0, 64'd4, 0);

    for (int i = 0; i < 12; i++) begin
      s   = 1'($urandom);
      acc = 1'($urandom);
      a   = $urandom;
      b   = $urandom;
      ai  = {$urandom, $urandom};
      if (i == 0) b = 32'h8000_0000;
      if (i == 1) a = 32'h7FFF_FFFF;
      txn("rand", s, acc, a, b, ai, model(s, acc, a, b, ai), (i % 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
